// File: rtl/lyra2_pack_fifo_pkg.sv
// Shared sizing helpers, types and board defaults for the Lyra2 input packing FIFO.
// The thresholds come from the Lyra2 core pipeline depth.
package lyra2_fifo_pkg;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

  localparam int PIPELINE_DEPTH   = 8;
  localparam int DEF_IN_WIDTH     = 32;
  localparam int DEF_OUT_WIDTH    = 256;
  localparam int DEF_DEPTH        = 128;
  localparam int DEF_RATIO        = DEF_OUT_WIDTH / DEF_IN_WIDTH;
  localparam int DEF_ALMOST_EMPTY = PIPELINE_DEPTH;
  localparam int DEF_ALMOST_FULL  = DEF_DEPTH - PIPELINE_DEPTH;

  typedef logic [clog2(DEF_RATIO)-1:0] beat_idx_t;
  typedef logic [clog2(DEF_DEPTH):0]   fifo_cnt_t;

endpackage

// File: rtl/lyra2_pack_fifo_if.sv
// Narrow write stream plus wide FWFT read stream of the Lyra2 packing FIFO.
// The slave modport is the FIFO's view, master is the view of whoever drives it.
interface lyra2_pack_fifo_if #(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 256
);
  logic [IN_WIDTH-1:0]  s_data;
  logic                 s_valid;
  logic                 s_ready;
  logic [OUT_WIDTH-1:0] m_data;
  logic                 m_valid;
  logic                 m_ready;

  modport slave (
    input  s_data, s_valid, m_ready,
    output s_ready, m_data, m_valid
  );

  modport master (
    output s_data, s_valid, m_ready,
    input  s_ready, m_data, m_valid
  );
endinterface

// File: rtl/lyra2_pack_fifo_mem.sv
// Simple dual-port storage for the packing FIFO: synchronous write, asynchronous read,
// so it maps onto distributed RAM and gives first-word-fall-through reads.
module lyra2_fifo_mem
  import lyra2_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_OUT_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]        wdata,
  input  logic [clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]        rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/lyra2_pack_fifo.sv
// Width-upsizing FWFT FIFO: packs narrow beats LSB-first into wide entries for the Lyra2 core.
// Optional macro LYRA2_FIFO_STATS_EN adds wrap-around push/pop entry counters.
module lyra2_pack_fifo
  import lyra2_fifo_pkg::*;
#(
  parameter int IN_WIDTH     = DEF_IN_WIDTH,
  parameter int OUT_WIDTH    = DEF_OUT_WIDTH,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int ALMOST_EMPTY = DEF_ALMOST_EMPTY,
  parameter int ALMOST_FULL  = DEF_ALMOST_FULL
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  lyra2_pack_fifo_if.slave        bus,
  output logic [clog2(DEPTH):0]   count,
  output logic                    almost_empty,
  output logic                    almost_full
`ifdef LYRA2_FIFO_STATS_EN
  ,
  output logic [31:0]             push_cnt,
  output logic [31:0]             pop_cnt
`endif
);

  localparam int RATIO = OUT_WIDTH / IN_WIDTH;
  localparam int AW    = clog2(DEPTH);
  localparam int CW    = AW + 1;
  localparam int BIW   = (RATIO > 1) ? clog2(RATIO) : 1;
  localparam logic [BIW-1:0] LAST_BEAT = BIW'(RATIO - 1);

  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [BIW-1:0]       beat_idx;
  logic [OUT_WIDTH-1:0] pack_reg;
  logic [OUT_WIDTH-1:0] wr_data;
  logic                 clear;
  logic                 beat_fire;
  logic                 entry_push;
  logic                 entry_pop;

  assign clear       = rst | flush;
  assign bus.s_ready = (count != CW'(DEPTH));
  assign bus.m_valid = (count != '0);
  assign beat_fire   = bus.s_valid & bus.s_ready;
  assign entry_push  = beat_fire & (beat_idx == LAST_BEAT) & ~clear;
  assign entry_pop   = bus.m_valid & bus.m_ready & ~clear;

  assign almost_empty = (count <= CW'(ALMOST_EMPTY));
  assign almost_full  = (count >= CW'(ALMOST_FULL));

  // The final beat bypasses pack_reg so the full entry lands in memory on the same edge.
  always_comb begin
    wr_data = pack_reg;
    wr_data[(RATIO-1)*IN_WIDTH +: IN_WIDTH] = bus.s_data;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      beat_idx <= '0;
      pack_reg <= '0;
    end else if (beat_fire) begin
      pack_reg[int'(beat_idx)*IN_WIDTH +: IN_WIDTH] <= bus.s_data;
      beat_idx <= (beat_idx == LAST_BEAT) ? '0 : beat_idx + BIW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (entry_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (entry_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({entry_push, entry_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  lyra2_fifo_mem #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (entry_push),
    .waddr (wr_ptr),
    .wdata (wr_data),
    .raddr (rd_ptr),
    .rdata (bus.m_data)
  );

`ifdef LYRA2_FIFO_STATS_EN
  // Statistics survive flush so software can read totals across pipeline restarts.
  always_ff @(posedge clk) begin
    if (rst) begin
      push_cnt <= '0;
      pop_cnt  <= '0;
    end else begin
      if (entry_push) begin
        push_cnt <= push_cnt + 32'd1;
      end
      if (entry_pop) begin
        pop_cnt <= pop_cnt + 32'd1;
      end
    end
  end
`endif

endmodule
